// File: rtl/multi_cnt_bus.sv
// multi_cnt_bus: chan_p bus-programmable event counters with wrap/saturate, limit, sticky hit and combined irq
module multi_cnt_bus #(
    parameter int width_p = 10,
    parameter int chan_p  = 4
) (
    input  logic                      main_clk_i,
    input  logic                      main_rst_an_i,
    input  logic [1:0]                bus_trans_i,
    input  logic [31:0]               bus_addr_i,
    input  logic                      bus_write_i,
    input  logic [31:0]               bus_wdata_i,
    output logic                      bus_ready_o,
    output logic                      bus_resp_o,
    output logic [31:0]               bus_rdata_o,
    input  logic [chan_p-1:0]         evt_i,
    output logic [chan_p*width_p-1:0] cnt_o,
    output logic                      irq_o
);
    typedef enum logic {IDLE, RESP} state_t;
    state_t             r_state;
    logic [width_p-1:0] r_cnt   [chan_p];
    logic [width_p-1:0] r_limit [chan_p];
    logic [3:0]         r_ctrl  [chan_p];
    logic [chan_p-1:0]  r_hit;
    logic               r_irq;
    logic               w_req, w_err, w_wr, w_unused;
    logic [3:0]         w_ch;
    logic [1:0]         w_reg;
    logic [31:0]        w_rdata;
    logic [width_p-1:0] w_next  [chan_p];
    logic [chan_p-1:0]  w_sel, w_act, w_set, w_irq_en;

    assign w_unused = ^bus_wdata_i;
    assign irq_o    = r_irq;

    // bus request decode, address check and read-data mux
    always_comb begin
        w_req   = (r_state == IDLE) && (bus_trans_i != 2'b00);
        w_err   = (bus_addr_i[1:0] != 2'b00) || (bus_addr_i >= 32'(16 * chan_p));
        w_wr    = w_req && bus_write_i && !w_err;
        w_ch    = bus_addr_i[7:4];
        w_reg   = bus_addr_i[3:2];
        w_rdata = '0;
        w_sel   = '0;
        for (int c = 0; c < chan_p; c++) begin
            w_sel[c] = w_wr && (w_ch == 4'(c));
            if (w_ch == 4'(c))
                w_rdata = w_reg == 2'd0 ? 32'(r_cnt[c]) :
                          w_reg == 2'd1 ? 32'(r_ctrl[c]) :
                          w_reg == 2'd2 ? 32'(r_limit[c]) : 32'(r_hit[c]);
        end
    end

    // per-channel next count and hit-set; a CNT write in the same cycle swallows the event
    always_comb begin
        for (int c = 0; c < chan_p; c++) begin
            w_act[c]    = r_ctrl[c][0] && evt_i[c] && !(w_sel[c] && w_reg == 2'd0);
            w_irq_en[c] = r_ctrl[c][3];
            cnt_o[c*width_p +: width_p] = r_cnt[c];
            if (r_ctrl[c][2]) begin
                w_next[c] = (r_cnt[c] == '0) ? (r_ctrl[c][1] ? r_cnt[c] : r_limit[c]) : r_cnt[c] - width_p'(1);
                w_set[c]  = w_act[c] && ((r_cnt[c] == '0) ? !r_ctrl[c][1] : r_cnt[c] == width_p'(1));
            end else begin
                w_next[c] = (r_cnt[c] == r_limit[c]) ? (r_ctrl[c][1] ? r_cnt[c] : '0) : r_cnt[c] + width_p'(1);
                w_set[c]  = w_act[c] && ((r_cnt[c] == r_limit[c]) ? !r_ctrl[c][1] : (r_cnt[c] + width_p'(1)) == r_limit[c]);
            end
        end
    end

    // bus FSM: accept in IDLE, answer for exactly one cycle in RESP
    always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
        if (!main_rst_an_i) begin
            r_state     <= IDLE;
            bus_ready_o <= 1'b0;
            bus_resp_o  <= 1'b0;
            bus_rdata_o <= '0;
        end else if (r_state == IDLE) begin
            r_state     <= w_req ? RESP : IDLE;
            bus_ready_o <= w_req;
            bus_resp_o  <= w_req && w_err;
            bus_rdata_o <= (w_req && !w_err && !bus_write_i) ? w_rdata : '0;
        end else begin
            r_state     <= IDLE;
            bus_ready_o <= 1'b0;
            bus_resp_o  <= 1'b0;
            bus_rdata_o <= '0;
        end
    end

    // channel registers: bus writes, counting and sticky hit where set beats W1C
    always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
        if (!main_rst_an_i) begin
            for (int c = 0; c < chan_p; c++) begin
                r_cnt[c]   <= '0;
                r_ctrl[c]  <= '0;
                r_limit[c] <= '1;
            end
            r_hit <= '0;
        end else begin
            for (int c = 0; c < chan_p; c++) begin
                if (w_sel[c] && w_reg == 2'd0)
                    r_cnt[c] <= bus_wdata_i[width_p-1:0];
                else if (w_act[c])
                    r_cnt[c] <= w_next[c];
                if (w_sel[c] && w_reg == 2'd1)
                    r_ctrl[c] <= bus_wdata_i[3:0];
                if (w_sel[c] && w_reg == 2'd2)
                    r_limit[c] <= bus_wdata_i[width_p-1:0];
                r_hit[c] <= w_set[c] || (r_hit[c] && !(w_sel[c] && w_reg == 2'd3 && bus_wdata_i[0]));
            end
        end
    end

    // combined interrupt, registered one cycle behind the hit flags
    always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
        if (!main_rst_an_i)
            r_irq <= 1'b0;
        else
            r_irq <= |(r_hit & w_irq_en);
    end
endmodule

// File: tb/tb_multi_cnt_bus.sv
// tb_multi_cnt_bus: directed and random checks of multi_cnt_bus against a behavioural register/counter model
module tb_multi_cnt_bus;
    localparam int     W   = 10;
    localparam int     CH  = 4;
    localparam longint MAX = (64'd1 << W) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [1:0]    d_trans = '0;
    logic [31:0]   d_addr = '0;
    logic          d_write = 1'b0;
    logic [31:0]   d_wdata = '0;
    logic [CH-1:0] d_evt = '0;
    logic          bus_ready_o, bus_resp_o, irq_o;
    logic [31:0]   bus_rdata_o;
    logic [CH*W-1:0] cnt_o;

    int checks = 0;
    int errors = 0;

    longint      m_cnt[CH], m_lim[CH];
    logic [3:0]  m_ctrl[CH];
    bit          m_hit[CH];
    bit          m_irq, m_busy, e_ready, e_resp;
    logic [31:0] e_rdata;

    multi_cnt_bus #(.width_p(W), .chan_p(CH)) dut (
        .main_clk_i(clk), .main_rst_an_i(rst_n), .bus_trans_i(d_trans), .bus_addr_i(d_addr),
        .bus_write_i(d_write), .bus_wdata_i(d_wdata), .bus_ready_o(bus_ready_o), .bus_resp_o(bus_resp_o),
        .bus_rdata_o(bus_rdata_o), .evt_i(d_evt), .cnt_o(cnt_o), .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_cnt[c] = 0; m_ctrl[c] = 0; m_lim[c] = MAX; m_hit[c] = 0;
        end
        m_irq = 0; m_busy = 0; e_ready = 0; e_resp = 0; e_rdata = 0;
    endtask

    function automatic logic [31:0] rd(int ch, int rg);
        case (rg)
            0:       return 32'(m_cnt[ch]);
            1:       return 32'(m_ctrl[ch]);
            2:       return 32'(m_lim[ch]);
            default: return 32'(m_hit[ch]);
        endcase
    endfunction

    // one clock of the register-map / counter rules, applied to the inputs currently driven
    task automatic model_step();
        bit req, err, wsel, set, nirq;
        int ch, rg;
        longint wv;
        req = !m_busy && d_trans != 0;
        err = d_addr[1:0] != 0 || d_addr >= 32'(16 * CH);
        ch  = int'(d_addr[7:4]);
        rg  = int'(d_addr[3:2]);
        e_ready = req;
        e_resp  = req && err;
        e_rdata = (req && !err && !d_write) ? rd(ch, rg) : 32'd0;
        nirq = 0;
        for (int c = 0; c < CH; c++) if (m_hit[c] && m_ctrl[c][3]) nirq = 1;
        wv = longint'(d_wdata) & MAX;
        for (int c = 0; c < CH; c++) begin
            wsel = req && !err && d_write && ch == c;
            set  = 0;
            if (m_ctrl[c][0] && d_evt[c] && !(wsel && rg == 0)) begin
                if (!m_ctrl[c][2]) begin
                    if (m_cnt[c] == m_lim[c]) begin
                        if (!m_ctrl[c][1]) begin m_cnt[c] = 0; set = 1; end
                    end else begin
                        m_cnt[c] = (m_cnt[c] + 1) & MAX;
                        set = m_cnt[c] == m_lim[c];
                    end
                end else begin
                    if (m_cnt[c] == 0) begin
                        if (!m_ctrl[c][1]) begin m_cnt[c] = m_lim[c]; set = 1; end
                    end else begin
                        m_cnt[c] = m_cnt[c] - 1;
                        set = m_cnt[c] == 0;
                    end
                end
            end
            if (wsel)
                case (rg)
                    0: m_cnt[c] = wv;
                    1: m_ctrl[c] = d_wdata[3:0];
                    2: m_lim[c] = wv;
                    default: if (d_wdata[0]) m_hit[c] = 0;
                endcase
            if (set) m_hit[c] = 1;
        end
        m_irq  = nirq;
        m_busy = req;
    endtask

    task automatic cmp_all();
        logic [CH*W-1:0] ec;
        for (int c = 0; c < CH; c++) ec[c*W +: W] = m_cnt[c][W-1:0];
        chk("ready", bus_ready_o, e_ready);
        chk("resp", bus_resp_o, e_resp);
        chk("rdata", bus_rdata_o, e_rdata);
        chk("cnt", cnt_o, ec);
        chk("irq", irq_o, m_irq);
    endtask

    task automatic step();
        if (rst_n) model_step();
        @(posedge clk);
        #1;
        cmp_all();
    endtask

    task automatic req(input logic w, input logic [31:0] a, input logic [31:0] d);
        d_trans = 2'b01; d_addr = a; d_write = w; d_wdata = d;
        step();
        d_trans = 2'b00;
    endtask

    task automatic idle();
        d_trans = 2'b00;
        step();
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        req(1'b1, a, d);
        idle();
    endtask

    initial begin
        int seq0[5] = '{1, 2, 3, 0, 1};
        int seq1[4] = '{1, 0, 0, 0};
        model_reset();
        #2 rst_n = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        cmp_all();
        rst_n = 1'b1;

        req(1'b0, 32'h8, 0);
        chk("t1_ready", bus_ready_o, 1);
        chk("t1_limit", bus_rdata_o, 32'h3FF);
        idle();
        chk("t1_ready_drop", bus_ready_o, 0);
        req(1'b0, 32'h0, 0);
        chk("t1_cnt0", bus_rdata_o, 0);
        idle();

        wr(32'h8, 3);
        wr(32'h4, 32'h9);
        for (int i = 0; i < 5; i++) begin
            d_evt = 4'b0001;
            step();
            chk("t2_cnt", cnt_o[W-1:0], seq0[i]);
            if (i == 2) chk("t2_irq_late", irq_o, 0);
            if (i == 3) chk("t2_irq", irq_o, 1);
        end
        d_evt = '0;
        wr(32'hC, 1);
        idle();
        chk("t2_irq_clr", irq_o, 0);

        wr(32'h14, 32'h7);
        wr(32'h10, 2);
        for (int i = 0; i < 4; i++) begin
            d_evt = 4'b0010;
            step();
            chk("t3_cnt", cnt_o[W +: W], seq1[i]);
        end
        d_evt = '0;
        req(1'b0, 32'h1C, 0);
        chk("t3_hit", bus_rdata_o, 1);
        idle();

        req(1'b0, 32'h40, 0);
        chk("t4_resp", bus_resp_o, 1);
        chk("t4_rdata", bus_rdata_o, 0);
        idle();
        req(1'b1, 32'h6, 32'hFFFF);
        chk("t4_wresp", bus_resp_o, 1);
        idle();
        req(1'b0, 32'h4, 0);
        chk("t4_ctrl", bus_rdata_o, 32'h9);
        idle();

        wr(32'h24, 1);
        d_evt = 4'b0100;
        req(1'b1, 32'h20, 32'h55);
        d_evt = '0;
        chk("t5_cnt", cnt_o[2*W +: W], 32'h55);
        idle();
        wr(32'h28, 32'h56);
        d_evt = 4'b0100;
        req(1'b1, 32'h2C, 1);
        d_evt = '0;
        idle();
        req(1'b0, 32'h2C, 0);
        chk("t5_hit", bus_rdata_o, 1);
        idle();

        req(1'b0, 32'h8, 0);
        chk("t6_ready", bus_ready_o, 1);
        rst_n = 1'b0;
        #1;
        model_reset();
        cmp_all();
        d_trans = 2'b01;
        step();
        step();
        chk("t6_noready", bus_ready_o, 0);
        rst_n = 1'b1;
        req(1'b0, 32'h8, 0);
        chk("t6_after", bus_rdata_o, 32'h3FF);
        idle();

        for (int i = 0; i < 600; i++) begin
            d_evt = CH'($urandom);
            if (m_busy || $urandom_range(0, 2) == 0) begin
                int ch = $urandom_range(0, CH);
                int rg = $urandom_range(0, 3);
                d_trans = 2'($urandom_range(1, 3));
                d_write = 1'($urandom);
                d_addr  = 32'(ch * 16 + rg * 4) + (($urandom_range(0, 9) == 0) ? 32'($urandom_range(1, 3)) : 32'd0);
                if ($urandom_range(0, 19) == 0) d_addr = $urandom;
                d_wdata = $urandom;
                if ($urandom_range(0, 3) != 0) d_wdata = (d_wdata & ~32'(MAX)) | 32'($urandom_range(0, 12));
            end else
                d_trans = 2'b00;
            step();
        end
        d_trans = 2'b00;
        d_evt = '0;
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
